// File: rtl/outgoing_response_buffer_pkg.sv
// Shared AXI read-path types: AR request entry and R response beat entry.
package outgoing_response_buffer_pkg;

  localparam int unsigned IdWidthDef   = 8;
  localparam int unsigned DataWidthDef = 64;
  localparam int unsigned RespWidthDef = 2;
  localparam int unsigned AddrWidthDef = 32;

  typedef struct packed {
    logic [IdWidthDef-1:0]   id;
    logic [AddrWidthDef-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } ar_entry_t;

  typedef struct packed {
    logic [IdWidthDef-1:0]   id;
    logic [DataWidthDef-1:0] data;
    logic [RespWidthDef-1:0] resp;
    logic                    last;
  } r_entry_t;

endpackage

// File: rtl/r_if.sv
// AXI R channel bundle with sender/receiver views.
interface r_if #(
  parameter int unsigned ID_WIDTH   = outgoing_response_buffer_pkg::IdWidthDef,
  parameter int unsigned DATA_WIDTH = outgoing_response_buffer_pkg::DataWidthDef,
  parameter int unsigned RESP_WIDTH = outgoing_response_buffer_pkg::RespWidthDef
) ();
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;

  modport sender   (output valid, id, data, resp, last, input ready);
  modport receiver (input valid, id, data, resp, last, output ready);
endinterface

// File: rtl/rob_fifo_core.sv
// Circular FIFO: pointers, occupancy count and unreset storage, read is combinational.
module rob_fifo_core #(
  parameter int unsigned EntryW = 75,
  parameter int unsigned Depth  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [EntryW-1:0] wdata,
  output logic [EntryW-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CntW-1:0]   count;
  logic [EntryW-1:0] mem [Depth];
  logic              push_ok, pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
      if (pop_ok)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CntW'(Depth));
  assign empty = (count == '0);

endmodule

// File: rtl/outgoing_response_buffer.sv
// R-beat buffer toward the AXI master; optionally holds beats until a whole burst is stored.
module outgoing_response_buffer
  import outgoing_response_buffer_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = IdWidthDef,
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned RESP_WIDTH = RespWidthDef,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned STORE_FWD  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  r_if.receiver                      r_in,
  r_if.sender                        r_out,
  output logic                       Outgoing_buffer_full,
  output logic                       Outgoing_buffer_empty,
  output logic [$clog2(DEPTH+1)-1:0] burst_count
);
  localparam int unsigned EntryW = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);

  logic              push, pop, full, empty, fwd_active;
  logic [EntryW-1:0] wdata, rdata;

  assign r_in.ready = ~full;
  assign push       = r_in.valid & ~full;
  assign pop        = r_out.valid & r_out.ready;
  assign wdata      = {r_in.id, r_in.data, r_in.resp, r_in.last};
  assign {r_out.id, r_out.data, r_out.resp, r_out.last} = rdata;

  rob_fifo_core #(
    .EntryW (EntryW),
    .Depth  (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Full releases an over-long burst; fwd_active lets a started burst drain without its tail.
  assign r_out.valid = ~empty & ((STORE_FWD == 0) || (burst_count != '0) || full || fwd_active);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_count <= '0;
      fwd_active  <= 1'b0;
    end else begin
      case ({push & r_in.last, pop & rdata[0]})
        2'b10:   burst_count <= burst_count + CntW'(1);
        2'b01:   burst_count <= burst_count - CntW'(1);
        default: burst_count <= burst_count;
      endcase
      if (pop) fwd_active <= ~rdata[0];
    end
  end

  assign Outgoing_buffer_full  = full;
  assign Outgoing_buffer_empty = empty;

endmodule

// File: tb/tb_outgoing_response_buffer.sv
// Directed and randomized checks of the outgoing response buffer in both forwarding modes.
module tb_outgoing_response_buffer;
  import outgoing_response_buffer_pkg::*;

  localparam int unsigned NBeats = 10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_full, s_empty, c_full, c_empty;
  logic [4:0] s_bc, c_bc;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  r_if s_in ();
  r_if s_out ();
  r_if c_in ();
  r_if c_out ();

  outgoing_response_buffer #(.STORE_FWD(1)) dut_sf (
    .clk                   (clk),
    .rst                   (rst),
    .r_in                  (s_in),
    .r_out                 (s_out),
    .Outgoing_buffer_full  (s_full),
    .Outgoing_buffer_empty (s_empty),
    .burst_count           (s_bc)
  );

  outgoing_response_buffer #(.STORE_FWD(0)) dut_ct (
    .clk                   (clk),
    .rst                   (rst),
    .r_in                  (c_in),
    .r_out                 (c_out),
    .Outgoing_buffer_full  (c_full),
    .Outgoing_buffer_empty (c_empty),
    .burst_count           (c_bc)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    s_in.valid = 1'b0; s_in.id = '0; s_in.data = '0; s_in.resp = '0; s_in.last = 1'b0;
    c_in.valid = 1'b0; c_in.id = '0; c_in.data = '0; c_in.resp = '0; c_in.last = 1'b0;
    s_out.ready = 1'b0;
    c_out.ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic s_drive(input logic [7:0] id, input logic [63:0] d, input logic l);
    s_in.valid = 1'b1; s_in.id = id; s_in.data = d; s_in.resp = d[1:0]; s_in.last = l;
  endtask

  logic     in_acc, out_pop, prev_valid, prev_pop;
  r_entry_t q[$];
  r_entry_t exp_e, cur_e, prev_e;
  int       sent, recv, burst_left, cyc, model_bc;

  initial begin
    rst = 1'b0;
    idle_all();
    #1;
    // Reset values while rst is held low
    check("rst_valid", s_out.valid, 0);
    check("rst_ready", s_in.ready, 1);
    check("rst_empty", s_empty, 1);
    check("rst_full", s_full, 0);
    check("rst_bc", s_bc, 0);
    step();
    rst = 1'b1;

    // Store-and-forward: 4-beat burst released only after its last beat
    for (int i = 0; i < 4; i++) begin
      s_drive(8'h3, 64'h100 + i, i == 3);
      step();
      if (i < 3) check("sf_hold", s_out.valid, 0);
    end
    s_in.valid = 1'b0;
    check("sf_valid", s_out.valid, 1);
    check("sf_bc1", s_bc, 1);
    s_out.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("sf_data", s_out.data, 64'h100 + i);
      check("sf_id", s_out.id, 8'h3);
      check("sf_last", s_out.last, i == 3);
      step();
    end
    check("sf_bc0", s_bc, 0);
    check("sf_empty", s_empty, 1);

    // 16 beats without last: full releases the stuck burst
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_drive(8'(i), 64'h200 + i, 1'b0);
      step();
    end
    check("full_flag", s_full, 1);
    check("full_ready", s_in.ready, 0);
    check("full_valid", s_out.valid, 1);
    check("full_bc", s_bc, 0);
    s_in.valid = 1'b0;
    s_out.ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("full_data", s_out.data, 64'h200 + i);
      step();
    end
    check("full_drained", s_empty, 1);

    // Two bursts with a stall inside the first
    do_reset();
    s_drive(8'h1, 64'hA0, 1'b0); step();
    s_drive(8'h1, 64'hA1, 1'b1); step();
    s_drive(8'h2, 64'hB0, 1'b0); step();
    s_drive(8'h2, 64'hB1, 1'b0); step();
    s_drive(8'h2, 64'hB2, 1'b1); step();
    s_in.valid = 1'b0;
    check("two_bc2", s_bc, 2);
    s_out.ready = 1'b1;
    check("two_a0", s_out.data, 64'hA0);
    step();
    s_out.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", s_out.valid, 1);
      check("stall_data", s_out.data, 64'hA1);
      step();
    end
    s_out.ready = 1'b1;
    check("two_a1_last", s_out.last, 1);
    step();
    check("two_bc1", s_bc, 1);
    for (int i = 0; i < 3; i++) begin
      check("two_b", s_out.data, 64'hB0 + i);
      step();
    end
    check("two_bc0", s_bc, 0);

    // Reset in the middle of an 8-beat burst
    do_reset();
    for (int i = 0; i < 6; i++) begin
      s_drive(8'h9, 64'h300 + i, 1'b0);
      step();
    end
    check("mid_not_empty", s_empty, 0);
    s_in.valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_empty", s_empty, 1);
    check("mid_rst_valid", s_out.valid, 0);
    check("mid_rst_ready", s_in.ready, 1);
    check("mid_rst_full", s_full, 0);
    check("mid_rst_bc", s_bc, 0);
    step();
    rst = 1'b1;
    s_drive(8'h7, 64'h55, 1'b1);
    step();
    s_in.valid = 1'b0;
    check("post_valid", s_out.valid, 1);
    check("post_data", s_out.data, 64'h55);
    check("post_bc", s_bc, 1);
    s_out.ready = 1'b1;
    step();
    check("post_alone", s_out.valid, 0);
    check("post_empty", s_empty, 1);

    // Cut-through: occupancy of 5 held under continuous traffic past pointer wrap
    do_reset();
    for (int i = 0; i < 5; i++) begin
      c_in.valid = 1'b1; c_in.data = 64'(i); c_in.last = 1'b0;
      step();
      if (i == 0) check("ct_valid", c_out.valid, 1);
    end
    c_out.ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      c_in.data = 64'(5 + k);
      check("ct_data", c_out.data, 64'(k));
      check("ct_level", {c_full, c_empty}, 2'b00);
      step();
    end
    c_in.valid = 1'b0;
    for (int k = 40; k < 45; k++) begin
      check("ct_drain", c_out.data, 64'(k));
      step();
    end
    check("ct_empty", c_empty, 1);

    // Randomized traffic against a scoreboard, store-and-forward instance
    do_reset();
    sent = 0; recv = 0; burst_left = 0; cyc = 0;
    in_acc = 1'b0; prev_valid = 1'b0; prev_pop = 1'b0; prev_e = '0;
    while (recv < NBeats && cyc < 60000) begin
      if (!s_in.valid || in_acc) begin
        if (sent < NBeats && $urandom_range(0, 3) != 0) begin
          if (burst_left == 0) burst_left = $urandom_range(1, 4);
          s_drive(8'($urandom), {$urandom, $urandom}, (burst_left == 1) || (sent == NBeats - 1));
          s_in.resp = 2'($urandom);
        end else begin
          s_in.valid = 1'b0;
        end
      end
      s_out.ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cur_e = r_entry_t'{s_out.id, s_out.data, s_out.resp, s_out.last};
      model_bc = 0;
      foreach (q[j]) if (q[j].last) model_bc++;
      check("rand_bc", s_bc, model_bc);
      check("rand_bc_le_count", 128'(s_bc <= q.size()), 1);
      if (prev_valid && !prev_pop) check("rand_stable", {s_out.valid, cur_e}, {1'b1, prev_e});
      in_acc  = s_in.valid & s_in.ready;
      out_pop = s_out.valid & s_out.ready;
      if (out_pop) begin
        if (q.size() == 0) begin
          check("rand_underflow", q.size(), 1);
        end else begin
          exp_e = q.pop_front();
          check("rand_beat", cur_e, exp_e);
        end
        recv++;
      end
      if (in_acc) begin
        q.push_back(r_entry_t'{s_in.id, s_in.data, s_in.resp, s_in.last});
        sent++;
        burst_left = (burst_left > 0) ? burst_left - 1 : 0;
      end
      prev_valid = s_out.valid;
      prev_pop   = out_pop;
      prev_e     = cur_e;
      cyc++;
      step();
    end
    check("rand_received", recv, NBeats);
    check("rand_final_empty", s_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
